// File: rtl/coherence_mem_arbiter.sv
// Multi-core memory arbiter: round-robin grants of fetch/read/writeback onto one RAM
// port, with MSI snoop broadcast and cache-to-cache supply from a Modified holder.
module coherence_mem_arbiter #(
  parameter int CPUS   = 2,
  parameter int WORD_W = 32
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [CPUS-1:0]          iREN,
  input  logic [CPUS*WORD_W-1:0]   iaddr,
  input  logic [CPUS-1:0]          dREN,
  input  logic [CPUS-1:0]          dWEN,
  input  logic [CPUS*WORD_W-1:0]   daddr,
  input  logic [CPUS*WORD_W-1:0]   dstore,
  input  logic [CPUS-1:0]          ccwrite,
  input  logic [CPUS-1:0]          cctrans,
  output logic [CPUS-1:0]          iwait,
  output logic [CPUS*WORD_W-1:0]   iload,
  output logic [CPUS-1:0]          dwait,
  output logic [CPUS*WORD_W-1:0]   dload,
  output logic [CPUS-1:0]          ccwait,
  output logic [CPUS-1:0]          ccinv,
  output logic [CPUS*WORD_W-1:0]   ccsnoopaddr,
  output logic                     ramREN,
  output logic                     ramWEN,
  output logic [WORD_W-1:0]        ramaddr,
  output logic [WORD_W-1:0]        ramstore,
  input  logic [WORD_W-1:0]        ramload,
  input  logic [1:0]               ramstate,
  output logic [2:0]               dbg_state,
  output logic [2:0]               dbg_rr
);

  localparam int IW = (CPUS > 1) ? $clog2(CPUS) : 1;
  localparam logic [1:0] RAM_ACCESS = 2'd2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    MEMWR  = 3'd1,
    SNOOP  = 3'd2,
    C2C    = 3'd3,
    MEMRD  = 3'd4,
    IFETCH = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   g_q, g_d;
  logic [IW-1:0]   s_q, s_d;
  logic [IW-1:0]   rr_q, rr_d;

  logic [IW:0]     pick_w, pick_r, pick_i;
  logic            snoop_hold, c2c_hit;
  logic [IW-1:0]   c2c_idx;
  logic            ram_acc;

  // Returns {valid, index} of the first requester at or after ptr, wrapping.
  function automatic logic [IW:0] rr_pick(input logic [CPUS-1:0] req,
                                          input logic [IW-1:0] ptr);
    logic [IW:0] res;
    int          idx;
    res = '0;
    for (int k = CPUS - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % CPUS;
      if (req[idx]) res = {1'b1, IW'(idx)};
    end
    return res;
  endfunction

  function automatic logic [IW-1:0] rr_next(input logic [IW-1:0] win);
    return IW'((int'(win) + 1) % CPUS);
  endfunction

  assign ram_acc   = (ramstate == RAM_ACCESS);
  assign dbg_state = state_q;
  assign dbg_rr    = 3'(rr_q);

  always_comb begin
    pick_w = rr_pick(dWEN, rr_q);
    pick_r = rr_pick(dREN, rr_q);
    pick_i = rr_pick(iREN, rr_q);
  end

  // Snoop responses from every cache other than the requester; lowest supplier wins.
  always_comb begin
    snoop_hold = 1'b0;
    c2c_hit    = 1'b0;
    c2c_idx    = '0;
    for (int j = CPUS - 1; j >= 0; j--) begin
      if (IW'(j) != g_q) begin
        if (cctrans[j] && !dWEN[j]) snoop_hold = 1'b1;
        if (cctrans[j] && ccwrite[j] && dWEN[j]) begin
          c2c_hit = 1'b1;
          c2c_idx = IW'(j);
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    s_d     = s_q;
    rr_d    = rr_q;
    case (state_q)
      IDLE: begin
        if (pick_w[IW]) begin
          g_d     = pick_w[IW-1:0];
          rr_d    = rr_next(pick_w[IW-1:0]);
          state_d = MEMWR;
        end else if (pick_r[IW]) begin
          g_d     = pick_r[IW-1:0];
          rr_d    = rr_next(pick_r[IW-1:0]);
          state_d = SNOOP;
        end else if (pick_i[IW]) begin
          g_d     = pick_i[IW-1:0];
          rr_d    = rr_next(pick_i[IW-1:0]);
          state_d = IFETCH;
        end
      end
      MEMWR: begin
        if (!dWEN[g_q] || ram_acc) state_d = IDLE;
      end
      SNOOP: begin
        if (!dREN[g_q]) begin
          state_d = IDLE;
        end else if (snoop_hold) begin
          state_d = SNOOP;
        end else if (c2c_hit) begin
          s_d     = c2c_idx;
          state_d = C2C;
        end else begin
          state_d = MEMRD;
        end
      end
      C2C, MEMRD: begin
        if (!dREN[g_q] || ram_acc) state_d = IDLE;
      end
      IFETCH: begin
        if (!iREN[g_q] || ram_acc) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      g_q     <= '0;
      s_q     <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      s_q     <= s_d;
      rr_q    <= rr_d;
    end
  end

  // Completion only when the granted request is still present in the ACCESS cycle.
  always_comb begin
    iwait       = '1;
    dwait       = '1;
    iload       = {CPUS{ramload}};
    dload       = {CPUS{ramload}};
    ccwait      = '0;
    ccinv       = '0;
    ccsnoopaddr = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    case (state_q)
      MEMWR: begin
        ramWEN   = 1'b1;
        ramaddr  = daddr[int'(g_q)*WORD_W +: WORD_W];
        ramstore = dstore[int'(g_q)*WORD_W +: WORD_W];
        if (ram_acc && dWEN[g_q]) dwait[g_q] = 1'b0;
      end
      SNOOP: begin
        for (int j = 0; j < CPUS; j++) begin
          if (IW'(j) != g_q) begin
            ccwait[j]                        = 1'b1;
            ccinv[j]                         = ccwrite[g_q];
            ccsnoopaddr[j*WORD_W +: WORD_W]  = daddr[int'(g_q)*WORD_W +: WORD_W];
          end
        end
      end
      C2C: begin
        for (int j = 0; j < CPUS; j++) begin
          if (IW'(j) != g_q) begin
            ccwait[j]                        = 1'b1;
            ccsnoopaddr[j*WORD_W +: WORD_W]  = daddr[int'(g_q)*WORD_W +: WORD_W];
          end
        end
        dload[int'(g_q)*WORD_W +: WORD_W] = dstore[int'(s_q)*WORD_W +: WORD_W];
        ramWEN   = 1'b1;
        ramaddr  = daddr[int'(s_q)*WORD_W +: WORD_W];
        ramstore = dstore[int'(s_q)*WORD_W +: WORD_W];
        if (ram_acc && dREN[g_q]) begin
          dwait[g_q] = 1'b0;
          dwait[s_q] = 1'b0;
        end
      end
      MEMRD: begin
        ramREN  = 1'b1;
        ramaddr = daddr[int'(g_q)*WORD_W +: WORD_W];
        if (ram_acc && dREN[g_q]) dwait[g_q] = 1'b0;
      end
      IFETCH: begin
        ramREN  = 1'b1;
        ramaddr = iaddr[int'(g_q)*WORD_W +: WORD_W];
        if (ram_acc && iREN[g_q]) iwait[g_q] = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/coherence_mem_arbiter.md
Name: coherence_mem_arbiter

Overview:
- N-CPU memory controller that arbitrates instruction fetches, data reads and data writebacks from per-CPU caches onto a single RAM port.
- Implements snoop broadcast for MSI coherence, with cache-to-cache transfer from a Modified holder plus a simultaneous memory writeback.
- Sits between the per-CPU icache/dcache pairs and the RAM model.
- Generalises the single-CPU controller to CPUS cores with fair round-robin arbitration.

Parameters:
- CPUS, 2, number of cores; legal range 1..8.
- WORD_W, 32, data and address width.

Ports:
- CLK  input  1  system clock.
- RST  input  1  synchronous reset, active-high.
- iREN  input  CPUS  per-CPU instruction read request.
- iaddr  input  CPUS*WORD_W  per-CPU fetch address.
- dREN  input  CPUS  per-CPU data read request.
- dWEN  input  CPUS  per-CPU data write (writeback or supply) request.
- daddr  input  CPUS*WORD_W  per-CPU data address.
- dstore  input  CPUS*WORD_W  per-CPU write data.
- ccwrite  input  CPUS  requester: read-for-ownership; snooper: line held Modified.
- cctrans  input  CPUS  cache state transitioning / snoop response valid.
- iwait  output  CPUS  per-CPU instruction stall; 0 for exactly one cycle on completion.
- iload  output  CPUS*WORD_W  per-CPU fetch data.
- dwait  output  CPUS  per-CPU data stall; 0 for exactly one cycle on completion.
- dload  output  CPUS*WORD_W  per-CPU read data.
- ccwait  output  CPUS  snoop in progress toward this cache.
- ccinv  output  CPUS  invalidate the line at ccsnoopaddr.
- ccsnoopaddr  output  CPUS*WORD_W  snooped address.
- ramREN  output  1  RAM read enable.
- ramWEN  output  1  RAM write enable.
- ramaddr  output  WORD_W  RAM address.
- ramstore  output  WORD_W  RAM write data.
- ramload  input  WORD_W  RAM read data.
- ramstate  input  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3.

Behaviour:
- Registered state: fsm state, grant index g, supplier index s, round-robin pointer rr. All outputs are combinational from these and the inputs.
- Reset (RST high at a CLK edge), also mid-operation: state=IDLE, rr=0, g=s=0.
  - Output values in IDLE/reset: iwait=dwait=all 1s, ccwait=ccinv=0, ramREN=ramWEN=0, ramaddr=ramstore=0, ccsnoopaddr=0.
  - iload[k]=dload[k]=ramload for all k, except dload[g] in C2C (see C2C).
  - An in-flight RAM op is dropped without acknowledgement.
- IDLE: class priority is dWEN, then dREN, then iREN. Within a class the winner is the first requesting CPU at or after rr, modulo CPUS.
  - On grant: g=winner, rr=(winner+1) mod CPUS.
  - Next state: MEMWR, SNOOP or IFETCH respectively. With no request, stay in IDLE.
  - IDLE always costs one cycle; a grant is never completed in the same cycle.
- MEMWR: ramWEN=1, ramaddr=daddr[g], ramstore=dstore[g].
  - On ramstate==ACCESS: dwait[g]=0, then go to IDLE.
- SNOOP: for every j≠g, ccwait[j]=1, ccsnoopaddr[j]=daddr[g], ccinv[j]=ccwrite[g]. Minimum one cycle.
  - Stays in SNOOP while any j≠g has cctrans[j]=1 and dWEN[j]=0.
  - If any j≠g has cctrans[j]=1 and ccwrite[j]=1 and dWEN[j]=1: s=lowest such j, go to C2C.
  - Otherwise go to MEMRD.
  - CPUS=1: always goes to MEMRD after one cycle.
- C2C: ccwait[j≠g] held at 1; dload[g]=dstore[s]; ramWEN=1, ramaddr=daddr[s], ramstore=dstore[s].
  - On ACCESS: dwait[g]=0 and dwait[s]=0 in the same cycle, then go to IDLE.
- MEMRD: ramREN=1, ramaddr=daddr[g].
  - On ACCESS: dwait[g]=0, dload[g]=ramload, then go to IDLE.
- IFETCH: ramREN=1, ramaddr=iaddr[g].
  - On ACCESS: iwait[g]=0, iload[g]=ramload, then go to IDLE.
- ramstate BUSY, FREE or ERROR: hold the current state and outputs (ERROR is retried).
- Request withdrawal: if the granted request (iREN[g], dREN[g] or dWEN[g] as applicable) drops before ACCESS, go to IDLE next cycle with no wait deassertion.
- ramREN and ramWEN are never high together. At most one iwait/dwait pair completes per cycle, except the C2C pair.
- Transfers are word-granular; multi-word blocks are issued as successive requests.

Test Plan:
- Reset mid-MEMRD (RAM BUSY, RST high 1 cycle) -> next cycle state IDLE, ramREN=0, all waits 1, rr=0.
- CPUS=2, iREN=2'b11, RAM ACCESS after 2 cycles -> CPU0 served first, then CPU1.
  - iwait[0] low at cycle 3, iwait[1] low at cycle 6.
  - iload equals ramload (0xDEADBEEF) in each completion cycle.
- dWEN[1]=1 with iREN[0]=1 and dREN[0]=1 simultaneously -> MEMWR for CPU1 first, ramaddr=daddr[1]=0x40, ramstore=0x1234; then dREN[0], then iREN[0].
- CPU0 dREN with ccwrite[0]=1, daddr=0x80; CPU1 answers cctrans=1, ccwrite=1, dWEN=1, dstore=0xCAFE.
  - ccinv[1]=1 and ccsnoopaddr[1]=0x80 during SNOOP.
  - C2C: dload[0]=0xCAFE, ramWEN=1, ramaddr=0x80.
  - dwait[0] and dwait[1] both low in the same ACCESS cycle.
- CPU0 dREN, no snooper responds -> one SNOOP cycle, then MEMRD; dload[0]=ramload on ACCESS, ccinv=0 (ccwrite[0]=0).
- iREN[0] withdrawn during IFETCH before ACCESS -> IDLE next cycle, iwait[0] stays 1, ramREN=0.
